// File: rtl/sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_ctrl
// Description : Successive-approximation register controller. Holds the
//               track/hold switch in track for SAMPLE_CYCLES cycles, then
//               resolves one DAC bit per clock from MSB to LSB using the
//               comparator decision. It publishes the final code on RESULT
//               with a one-cycle EOC pulse.
// Ports       : C      - clock, rising-edge active
//               R      - synchronous active-high reset
//               START  - conversion request (IDLE / DONE only)
//               CMP    - comparator decision, 1 = Vin >= DAC
//               SAMPLE - track/hold control, 1 = track
//               DAC    - trial code to the DAC
//               RESULT - last completed conversion code
//               EOC    - end-of-conversion pulse (one cycle)
//               BUSY   - conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sar_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         C,
  input  logic         R,
  input  logic         START,
  input  logic         CMP,
  output logic         SAMPLE,
  output logic [N-1:0] DAC,
  output logic [N-1:0] RESULT,
  output logic         EOC,
  output logic         BUSY
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SMP  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] idx;
  logic [N-1:0]  next_code;

  // Trial update for the current bit: keep or clear bit[idx] from the
  // comparator, then arm the next lower bit. CMP only reaches state through
  // this path in CONV, so an unknown comparator elsewhere cannot leak out.
  always_comb begin
    next_code      = DAC;
    next_code[idx] = CMP;
    if (idx != '0) begin
      next_code[idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      SAMPLE <= 1'b0;
      DAC    <= '0;
      RESULT <= '0;
      EOC    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      EOC <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state  <= SMP;
            SAMPLE <= 1'b1;
            BUSY   <= 1'b1;
            cnt    <= '0;
            DAC    <= '0;
          end
        end

        SMP: begin
          if (cnt == 4'(SAMPLE_CYCLES - 1)) begin
            state      <= CONV;
            SAMPLE     <= 1'b0;
            DAC        <= '0;
            DAC[N-1]   <= 1'b1;
            idx        <= IW'(N - 1);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        CONV: begin
          DAC <= next_code;
          if (idx != '0) begin
            idx <= idx - 1'b1;
          end else begin
            state  <= DONE;
            RESULT <= next_code;
            EOC    <= 1'b1;
            BUSY   <= 1'b0;
          end
        end

        DONE: begin
          // Back-to-back request skips IDLE entirely.
          if (START) begin
            state  <= SMP;
            SAMPLE <= 1'b1;
            BUSY   <= 1'b1;
            cnt    <= '0;
            DAC    <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_ctrl
// Description : Directed self-checking bench for sar_ctrl (N=8,
//               SAMPLE_CYCLES=2). The comparator is modelled as
//               CMP = (vin_code >= DAC) and can be forced to X.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cmp;
  logic       sample;
  logic [7:0] dac;
  logic [7:0] result;
  logic       eoc;
  logic       busy;

  logic [7:0] vin_code;
  logic       cmp_x;

  int total = 0;
  int bad   = 0;

  sar_ctrl #(.N(8), .SAMPLE_CYCLES(2)) dut (
    .C      (clk),
    .R      (rst),
    .START  (start),
    .CMP    (cmp),
    .SAMPLE (sample),
    .DAC    (dac),
    .RESULT (result),
    .EOC    (eoc),
    .BUSY   (busy)
  );

  assign cmp = cmp_x ? 1'bx : (vin_code >= dac);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full single conversion starting from IDLE; edge 0 is the START edge.
  task automatic conv(input logic [7:0] vin, input logic [7:0] exp_res,
                      input logic [63:0] seq, input bit chk_seq);
    vin_code = vin;
    start    = 1'b1;
    tick();                                  // edge 0
    start = 1'b0;
    check("smp0_sample", sample, 1);
    check("smp0_busy",   busy,   1);
    check("smp0_dac",    dac,    0);
    tick();                                  // edge 1
    check("smp1_sample", sample, 1);
    tick();                                  // edge 2
    check("conv_sample", sample, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();                     // edges 3..9
      if (chk_seq) check($sformatf("dac_seq%0d", i), dac, seq[63-8*i -: 8]);
      check($sformatf("conv_busy%0d", i), busy, 1);
      check($sformatf("conv_eoc%0d", i),  eoc,  0);
    end
    tick();                                  // edge 10
    check("done_eoc",    eoc,    1);
    check("done_result", result, exp_res);
    check("done_busy",   busy,   0);
    check("done_dac",    dac,    exp_res);
    tick();                                  // edge 11
    check("post_eoc",    eoc,    0);
    check("post_result", result, exp_res);
  endtask

  task automatic wait_eoc(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (eoc === 1'b1) break;
    end
    if (eoc !== 1'b1) check("eoc_timeout", eoc, 1);
  endtask

  int n;
  int eoc_cnt;
  logic [7:0] cap;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    vin_code = 8'h00;
    cmp_x    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_sample", sample, 0);
    check("rst_dac",    dac,    0);
    check("rst_result", result, 0);
    check("rst_eoc",    eoc,    0);
    check("rst_busy",   busy,   0);

    // Mid-scale value with full trial sequence
    conv(8'hA5, 8'hA5, 64'h80C0A0B0A8A4A6A5, 1'b1);
    // Extremes
    conv(8'h00, 8'h00, 64'h8040201008040201, 1'b1);
    conv(8'hFF, 8'hFF, 64'h0, 1'b0);

    // START held high: two back-to-back conversions
    vin_code = 8'h3C;
    start    = 1'b1;
    tick();                                  // edge 0
    wait_eoc(40, n);
    check("b2b_first_lat", 16'(n), 10);
    check("b2b_first_res", result, 8'h3C);
    vin_code = 8'hC3;
    tick();                                  // edge 11, straight back into SMP
    check("b2b_no_idle_sample", sample, 1);
    check("b2b_no_idle_busy",   busy,   1);
    wait_eoc(40, n);
    check("b2b_spacing", 16'(n + 1), 11);
    check("b2b_second_res", result, 8'hC3);
    start = 1'b0;
    tick();
    tick();
    check("b2b_idle_busy", busy, 0);

    // START pulses during SMP and CONV are ignored
    vin_code = 8'h5A;
    start    = 1'b1;
    tick();                                  // edge 0
    start = 1'b0;
    tick();                                  // edge 1
    start = 1'b1;
    tick();                                  // edge 2 (SMP)
    start = 1'b0;
    tick();
    tick();                                  // edge 4
    start = 1'b1;
    tick();                                  // edge 5 (CONV)
    start   = 1'b0;
    eoc_cnt = 0;
    cap     = 8'h00;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (eoc === 1'b1) begin
        eoc_cnt++;
        cap = result;
      end
    end
    check("ign_eoc_count", 16'(eoc_cnt), 1);
    check("ign_result",    cap,          8'h5A);

    // Reset during the 4th CONV cycle
    vin_code = 8'h33;
    start    = 1'b1;
    tick();                                  // edge 0
    start = 1'b0;
    tick();
    tick();                                  // edge 2
    check("rstmid_result_hold", result, 8'h5A);
    tick();
    tick();
    tick();                                  // edge 5
    rst = 1'b1;
    tick();                                  // edge 6
    rst = 1'b0;
    check("rstmid_sample", sample, 0);
    check("rstmid_dac",    dac,    0);
    check("rstmid_result", result, 0);
    check("rstmid_eoc",    eoc,    0);
    check("rstmid_busy",   busy,   0);
    eoc_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (eoc !== 1'b0 || busy !== 1'b0) eoc_cnt++;
    end
    check("rstmid_quiet", 16'(eoc_cnt), 0);
    conv(8'h33, 8'h33, 64'h0, 1'b0);

    // Unknown comparator while idle
    cmp_x = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("x_dac%0d",    i), dac,    8'h33);
      check($sformatf("x_result%0d", i), result, 8'h33);
      check($sformatf("x_flags%0d",  i), {sample, eoc, busy}, 0);
    end
    cmp_x = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
